// File: rtl/mmu_xlate_arbiter.sv
// ============================================================================
// Module      : mmu_xlate_arbiter
// Description : Arbitrates IF/MEM ports onto one combinational direct-map
//               translator, registers results and quiesces around CSR writes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mmu_xlate_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int RR_EN     = 1,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_vaddr0,
    input  logic [ADDR_W-1:0] req_vaddr1,
    output logic [1:0]        req_ready,
    output logic              resp_valid,
    output logic              resp_port,
    output logic [ADDR_W-1:0] resp_paddr,
    output logic              resp_uncache,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] mmu_vaddr,
    input  logic [ADDR_W-1:0] mmu_paddr,
    input  logic              mmu_uncache,
    input  logic              csr_wr,
    output logic              csr_wr_ack
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYC - 1);

    logic [1:0] r_state;
    logic       r_flush_pend;
    logic       r_rr_ptr;
    logic [3:0] r_cnt;

    logic       w_can_issue;
    logic       w_grant_any;
    logic       w_grant_port;
    logic       w_enter_flush;

    // Grants are gated by rst so every output reads zero while reset is held.
    always_comb begin
        w_can_issue  = !rst
                     && ((r_state == ST_IDLE) || ((r_state == ST_BUSY) && resp_ready))
                     && !r_flush_pend && !csr_wr;
        w_grant_any  = 1'b0;
        w_grant_port = 1'b0;
        if (w_can_issue) begin
            if (RR_EN != 0) begin
                if (req_valid[r_rr_ptr]) begin
                    w_grant_any  = 1'b1;
                    w_grant_port = r_rr_ptr;
                end else if (req_valid[~r_rr_ptr]) begin
                    w_grant_any  = 1'b1;
                    w_grant_port = ~r_rr_ptr;
                end
            end else begin
                if (req_valid[1]) begin
                    w_grant_any  = 1'b1;
                    w_grant_port = 1'b1;
                end else if (req_valid[0]) begin
                    w_grant_any  = 1'b1;
                    w_grant_port = 1'b0;
                end
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        mmu_vaddr = '0;
        if (w_grant_any) begin
            req_ready = w_grant_port ? 2'b10 : 2'b01;
            mmu_vaddr = w_grant_port ? req_vaddr1 : req_vaddr0;
        end
    end

    // A write arriving in the final quiet cycle restarts the count, so no ack then.
    assign csr_wr_ack    = (r_state == ST_FLUSH) && (r_cnt == 4'd0) && !csr_wr;
    assign w_enter_flush = r_flush_pend || csr_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_flush_pend <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_cnt        <= 4'd0;
            resp_valid   <= 1'b0;
            resp_port    <= 1'b0;
            resp_paddr   <= '0;
            resp_uncache <= 1'b0;
        end else begin
            if (csr_wr) begin
                r_flush_pend <= 1'b1;
            end

            if (w_grant_any) begin
                resp_valid   <= 1'b1;
                resp_port    <= w_grant_port;
                resp_paddr   <= mmu_paddr;
                resp_uncache <= mmu_uncache;
                if (RR_EN != 0) begin
                    r_rr_ptr <= ~w_grant_port;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_enter_flush) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= CNT_LOAD;
                    end else if (w_grant_any) begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Slot leaves only on handshake; a pending flush waits for it.
                    if (resp_ready && !w_grant_any) begin
                        resp_valid <= 1'b0;
                        if (w_enter_flush) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= CNT_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (csr_wr) begin
                        r_cnt <= CNT_LOAD;
                    end else if (r_cnt == 4'd0) begin
                        r_flush_pend <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmu_xlate_arbiter.sv
// ============================================================================
// Module      : tb_mmu_xlate_arbiter
// Description : Directed scoreboard bench; DUT A round-robin, DUT B fixed prio.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mmu_xlate_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] noise;
    int n_cmp  = 0;
    int n_fail = 0;
    int acks_a = 0;
    int acks_b = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] paddr;
        logic        unc;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic [1:0]  a_req_valid, a_req_ready, b_req_valid, b_req_ready;
    logic [31:0] a_v0, a_v1, b_v0, b_v1;
    logic        a_resp_valid, a_resp_port, a_resp_uncache, a_resp_ready;
    logic        b_resp_valid, b_resp_port, b_resp_uncache, b_resp_ready;
    logic [31:0] a_resp_paddr, b_resp_paddr;
    logic [31:0] a_mmu_vaddr, a_mmu_paddr, b_mmu_vaddr, b_mmu_paddr;
    logic        a_mmu_uncache, b_mmu_uncache;
    logic        a_csr_wr, a_csr_wr_ack, b_csr_wr, b_csr_wr_ack;

    // Translator stand-in: strip the segment bits, uncached when vaddr[28] is set.
    assign a_mmu_paddr   = (a_mmu_vaddr & 32'h1FFF_FFFF) ^ noise;
    assign a_mmu_uncache = a_mmu_vaddr[28] ^ noise[0];
    assign b_mmu_paddr   = b_mmu_vaddr & 32'h1FFF_FFFF;
    assign b_mmu_uncache = b_mmu_vaddr[28];

    mmu_xlate_arbiter #(.ADDR_W(32), .RR_EN(1), .FLUSH_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_vaddr0(a_v0), .req_vaddr1(a_v1),
        .req_ready(a_req_ready),
        .resp_valid(a_resp_valid), .resp_port(a_resp_port),
        .resp_paddr(a_resp_paddr), .resp_uncache(a_resp_uncache),
        .resp_ready(a_resp_ready),
        .mmu_vaddr(a_mmu_vaddr), .mmu_paddr(a_mmu_paddr), .mmu_uncache(a_mmu_uncache),
        .csr_wr(a_csr_wr), .csr_wr_ack(a_csr_wr_ack)
    );

    mmu_xlate_arbiter #(.ADDR_W(32), .RR_EN(0), .FLUSH_CYC(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_vaddr0(b_v0), .req_vaddr1(b_v1),
        .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_port(b_resp_port),
        .resp_paddr(b_resp_paddr), .resp_uncache(b_resp_uncache),
        .resp_ready(b_resp_ready),
        .mmu_vaddr(b_mmu_vaddr), .mmu_paddr(b_mmu_paddr), .mmu_uncache(b_mmu_uncache),
        .csr_wr(b_csr_wr), .csr_wr_ack(b_csr_wr_ack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic p, input logic [31:0] pa, input logic u);
        qa.push_back('{port: p, paddr: pa, unc: u});
    endtask

    task automatic push_b(input logic p, input logic [31:0] pa, input logic u);
        qb.push_back('{port: p, paddr: pa, unc: u});
    endtask

    // Monitors: pop the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst && a_csr_wr_ack) acks_a++;
        if (!rst && a_resp_valid && a_resp_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_resp_unexpected: actual port %0d paddr %h, required no response",
                         a_resp_port, a_resp_paddr);
            end else begin
                ea = qa.pop_front();
                chk("a_resp", 64'({a_resp_port, a_resp_paddr, a_resp_uncache}),
                    64'({ea.port, ea.paddr, ea.unc}));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_csr_wr_ack) acks_b++;
        if (!rst && b_resp_valid && b_resp_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_resp_unexpected: actual port %0d paddr %h, required no response",
                         b_resp_port, b_resp_paddr);
            end else begin
                eb = qb.pop_front();
                chk("b_resp", 64'({b_resp_port, b_resp_paddr, b_resp_uncache}),
                    64'({eb.port, eb.paddr, eb.unc}));
            end
        end
    end

    initial begin
        rst = 1'b1; noise = '0;
        a_req_valid = 2'b01; a_v0 = '0; a_v1 = '0; a_resp_ready = 1'b0; a_csr_wr = 1'b0;
        b_req_valid = 2'b00; b_v0 = '0; b_v1 = '0; b_resp_ready = 1'b1; b_csr_wr = 1'b0;

        // Reset state, with a request already pending
        step(); step(); #3;
        chk("rst_resp", 64'({a_resp_valid, a_resp_port, a_resp_paddr, a_resp_uncache}), 64'(0));
        chk("rst_ctrl", 64'({a_req_ready, a_csr_wr_ack, a_mmu_vaddr}), 64'(0));

        // 1: single port-0 request, one-cycle latency
        step(); rst = 1'b0; a_req_valid = 2'b01; a_v0 = 32'h1C00_0000; a_resp_ready = 1'b1;
        push_a(1'b0, 32'h1C00_0000, 1'b1);
        #3 chk("t1_ready", 64'(a_req_ready), 64'(2'b01));
        chk("t1_mmu_vaddr", 64'(a_mmu_vaddr), 64'(32'h1C00_0000));
        step(); a_req_valid = 2'b00;
        #3 chk("t1_resp_valid", 64'(a_resp_valid), 64'(1));
        step();
        #3 chk("t1_idle", 64'(a_resp_valid), 64'(0));

        // 2: port 1 alone (pointer -> 0), then both ports alternate 0,1,0,1
        step(); a_req_valid = 2'b10; a_v1 = 32'h9000_1234;
        push_a(1'b1, 32'h1000_1234, 1'b1);
        #3 chk("t2_p1_ready", 64'(a_req_ready), 64'(2'b10));
        for (int i = 0; i < 4; i++) begin
            step(); a_req_valid = 2'b11;
            a_v0 = 32'h0000_1000 + 32'(16 * i);
            a_v1 = 32'hB000_2000 + 32'(16 * i);
            if (i % 2 == 0) push_a(1'b0, 32'h0000_1000 + 32'(16 * i), 1'b0);
            else            push_a(1'b1, 32'h1000_2000 + 32'(16 * i), 1'b1);
            #3 chk("t2_rr_ready", 64'(a_req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
        end

        // 3: response held under back-pressure while the translator output wanders
        step(); a_req_valid = 2'b01; a_v0 = 32'h0000_3000;
        push_a(1'b0, 32'h0000_3000, 1'b0);
        #3 chk("t3_ready", 64'(a_req_ready), 64'(2'b01));
        for (int i = 0; i < 5; i++) begin
            step(); a_resp_ready = 1'b0; a_req_valid = 2'b11; a_v1 = 32'hB000_4000;
            noise = 32'h5A5A_0000 + 32'(i * 32'h111);
            #3 chk("t3_hold", 64'({a_resp_valid, a_resp_port, a_resp_paddr, a_resp_uncache, a_req_ready}),
                   64'({1'b1, 1'b0, 32'h0000_3000, 1'b0, 2'b00}));
        end
        step(); noise = '0; a_resp_ready = 1'b1;
        push_a(1'b1, 32'h1000_4000, 1'b1);
        #3 chk("t3_regrant", 64'(a_req_ready), 64'(2'b10));
        step(); a_req_valid = 2'b00;
        step();
        #3 chk("t3_idle", 64'(a_resp_valid), 64'(0));

        // 4: CSR write while BUSY and back-pressured
        step(); a_req_valid = 2'b01; a_v0 = 32'h0000_5000;
        push_a(1'b0, 32'h0000_5000, 1'b0);
        #3 chk("t4_ready", 64'(a_req_ready), 64'(2'b01));
        step(); a_req_valid = 2'b11; a_v1 = 32'hB000_6000; a_resp_ready = 1'b0; a_csr_wr = 1'b1;
        #3 chk("t4_csr_block", 64'(a_req_ready), 64'(2'b00));
        step(); a_csr_wr = 1'b0;
        #3 chk("t4_busy_wait", 64'({a_req_ready, a_csr_wr_ack}), 64'(0));
        step();
        #3 chk("t4_busy_wait", 64'({a_req_ready, a_csr_wr_ack}), 64'(0));
        step(); a_resp_ready = 1'b1;
        #3 chk("t4_hs_nogrant", 64'(a_req_ready), 64'(2'b00));
        step();
        #3 chk("t4_flush1", 64'({a_resp_valid, a_req_ready, a_csr_wr_ack}), 64'(0));
        step();
        #3 chk("t4_flush2_ack", 64'({a_req_ready, a_csr_wr_ack}), 64'({2'b00, 1'b1}));
        step();
        push_a(1'b1, 32'h1000_6000, 1'b1);
        #3 chk("t4_resume", 64'({a_req_ready, a_csr_wr_ack}), 64'({2'b10, 1'b0}));
        step(); a_req_valid = 2'b00;
        #3 chk("t4_ack_once", 64'(a_csr_wr_ack), 64'(0));

        // 5: second CSR write in the first flush cycle restarts the count
        step(); a_csr_wr = 1'b1; a_req_valid = 2'b11; a_v0 = 32'h0000_7000;
        #3 chk("t5_block", 64'(a_req_ready), 64'(2'b00));
        step();
        #3 chk("t5_reload", 64'({a_req_ready, a_csr_wr_ack}), 64'(0));
        step(); a_csr_wr = 1'b0;
        #3 chk("t5_count", 64'({a_req_ready, a_csr_wr_ack}), 64'(0));
        step();
        #3 chk("t5_ack", 64'(a_csr_wr_ack), 64'(1));
        step();
        push_a(1'b0, 32'h0000_7000, 1'b0);
        #3 chk("t5_resume", 64'({a_req_ready, a_csr_wr_ack}), 64'({2'b01, 1'b0}));
        step(); a_req_valid = 2'b00;

        // 6: async reset while BUSY, then while FLUSH
        step(); a_resp_ready = 1'b0; a_req_valid = 2'b01; a_v0 = 32'h1C00_8000;
        #3 chk("t6_grant", 64'(a_req_ready), 64'(2'b01));
        step(); a_req_valid = 2'b11;
        #3 chk("t6_busy", 64'(a_resp_valid), 64'(1));
        #1 rst = 1'b1;
        #1 chk("t6_rst_resp", 64'({a_resp_valid, a_resp_port, a_resp_paddr, a_resp_uncache}), 64'(0));
        chk("t6_rst_ctrl", 64'({a_req_ready, a_csr_wr_ack, a_mmu_vaddr}), 64'(0));
        step(); step(); rst = 1'b0; a_req_valid = 2'b00; a_resp_ready = 1'b1;
        #3 chk("t6_idle", 64'(a_resp_valid), 64'(0));
        step(); a_csr_wr = 1'b1;
        step(); a_csr_wr = 1'b0;
        #1 rst = 1'b1;
        #1 chk("t6_flush_rst_ack", 64'(a_csr_wr_ack), 64'(0));
        step(); rst = 1'b0;
        step(); a_req_valid = 2'b01; a_v0 = 32'h0000_9000;
        push_a(1'b0, 32'h0000_9000, 1'b0);
        #3 chk("t6_post_rst_grant", 64'(a_req_ready), 64'(2'b01));
        step(); a_req_valid = 2'b00;
        step();
        chk("a_ack_count", 64'(acks_a), 64'(2));

        // 2b: fixed priority starves port 0 while port 1 keeps requesting
        for (int i = 0; i < 4; i++) begin
            step(); b_req_valid = 2'b11; b_v0 = 32'h0000_A000;
            b_v1 = 32'hB000_B000 + 32'(16 * i);
            push_b(1'b1, 32'h1000_B000 + 32'(16 * i), 1'b1);
            #3 chk("b_fixed_ready", 64'(b_req_ready), 64'(2'b10));
        end
        step(); b_req_valid = 2'b01;
        push_b(1'b0, 32'h0000_A000, 1'b0);
        #3 chk("b_p0_ready", 64'(b_req_ready), 64'(2'b01));
        step(); b_req_valid = 2'b00;
        step(); step();

        chk("a_queue_drained", 64'(qa.size()), 64'(0));
        chk("b_queue_drained", 64'(qb.size()), 64'(0));
        chk("b_ack_count", 64'(acks_b), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
